slave_ram_arbiter: RTL and testbench

- Shares the single write port and single read port of the 256x32 slave dual-port BRAM between two clients.
- Client A is the host register interface. Client B is the link frame receiver/transmitter.
- Per-port 2-way arbitration with req/ack handshakes. All RAM port signals are registered. Read data is returned with a valid pulse that accounts for the RAM's 1-cycle registered read.
- Sits directly between the clients and the BRAM. It is the only driver of the BRAM ports.

---
 rtl/slave_ram_pkg.sv | 21 ++
 rtl/slave_ram_arbiter_arb2_rr.sv | 46 ++++
 rtl/slave_ram_arbiter.sv | 116 +++++++++++
 tb/tb_slave_ram_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/slave_ram_pkg.sv
// Shared constants and types for the slave BRAM arbiter.
package slave_ram_pkg;

  localparam int SLV_RAM_ADDR_W = 8;
  localparam int SLV_RAM_DATA_W = 32;

  // Client indices into the 2-bit request/grant vectors.
  localparam logic CLI_A = 1'b0;
  localparam logic CLI_B = 1'b1;

  // Arbitration modes.
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // One in-flight read: whether it exists and which client owns it.
  typedef struct packed {
    logic valid;
    logic cli;
  } rd_owner_t;

endpackage

// File: rtl/slave_ram_arbiter_arb2_rr.sv
// Two-requester arbiter with an exclude mask and a favoured-client pointer.
// The grant is combinational; the parent registers it onto the RAM port.
module arb2_rr
  import slave_ram_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] excl,
  output logic [1:0] grant
);

  // Client favoured on the next contention; A after reset.
  logic       ptr_reg;
  logic       ptr_next;
  logic [1:0] eligible;

  // Pick a winner among eligible requesters and derive the next pointer.
  always_comb begin
    eligible = req & ~excl;
    grant    = 2'b00;
    if (eligible == 2'b11) begin
      if (ARB_MODE == ARB_RR) begin
        grant = (ptr_reg == CLI_B) ? 2'b10 : 2'b01;
      end else begin
        grant = 2'b01;
      end
    end else if (eligible[CLI_A]) begin
      grant = 2'b01;
    end else if (eligible[CLI_B]) begin
      grant = 2'b10;
    end
    ptr_next = ptr_reg;
    if (grant[CLI_A]) ptr_next = CLI_B;
    if (grant[CLI_B]) ptr_next = CLI_A;
  end

  // Pointer moves only when somebody is granted.
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_reg <= CLI_A;
    else        ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/slave_ram_arbiter.sv
// Shares the write and read ports of the 256x32 slave BRAM between the host
// register interface (A) and the link frame engine (B).
module slave_ram_arbiter
  import slave_ram_pkg::*;
#(
  parameter int ADDR_W   = SLV_RAM_ADDR_W,
  parameter int DATA_W   = SLV_RAM_DATA_W,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_a_w_req,
  input  logic [ADDR_W-1:0] i_a_w_addr,
  input  logic [DATA_W-1:0] i_a_w_data,
  output logic              o_a_w_ack,
  input  logic              i_b_w_req,
  input  logic [ADDR_W-1:0] i_b_w_addr,
  input  logic [DATA_W-1:0] i_b_w_data,
  output logic              o_b_w_ack,
  input  logic              i_a_r_req,
  input  logic [ADDR_W-1:0] i_a_r_addr,
  output logic              o_a_r_ack,
  output logic              o_a_r_valid,
  input  logic              i_b_r_req,
  input  logic [ADDR_W-1:0] i_b_r_addr,
  output logic              o_b_r_ack,
  output logic              o_b_r_valid,
  output logic [DATA_W-1:0] o_r_data,
  output logic [ADDR_W-1:0] o_slave_w_ram_addr,
  output logic              o_slave_w_ram_ce,
  output logic [DATA_W-1:0] o_slave_w_ram_din,
  output logic [ADDR_W-1:0] o_slave_r_ram_addr,
  output logic              o_slave_r_ram_ce,
  input  logic [DATA_W-1:0] i_slave_r_ram_dout
);

  logic [1:0]        w_grant;
  logic [1:0]        r_grant;
  logic [1:0]        w_ack_reg;
  logic [1:0]        r_ack_reg;
  logic              w_ce_reg;
  logic [ADDR_W-1:0] w_addr_reg;
  logic [DATA_W-1:0] w_din_reg;
  logic              r_ce_reg;
  logic [ADDR_W-1:0] r_addr_reg;
  rd_owner_t         owner_reg;

  // A client acked this cycle sits out arbitration, so a held req re-arms
  // only on the following cycle.
  arb2_rr #(.ARB_MODE(ARB_MODE)) u_w_arb (
    .clk   (i_clk),
    .rst_n (i_rst),
    .req   ({i_b_w_req, i_a_w_req}),
    .excl  (w_ack_reg),
    .grant (w_grant)
  );

  arb2_rr #(.ARB_MODE(ARB_MODE)) u_r_arb (
    .clk   (i_clk),
    .rst_n (i_rst),
    .req   ({i_b_r_req, i_a_r_req}),
    .excl  (r_ack_reg),
    .grant (r_grant)
  );

  // Register the write winner onto the BRAM write port; addr/din hold when idle.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      w_ack_reg  <= 2'b00;
      w_ce_reg   <= 1'b0;
      w_addr_reg <= '0;
      w_din_reg  <= '0;
    end else begin
      w_ack_reg <= w_grant;
      w_ce_reg  <= |w_grant;
      if (w_grant[CLI_B]) begin
        w_addr_reg <= i_b_w_addr;
        w_din_reg  <= i_b_w_data;
      end else if (w_grant[CLI_A]) begin
        w_addr_reg <= i_a_w_addr;
        w_din_reg  <= i_a_w_data;
      end
    end
  end

  // Register the read winner and track who owns the word arriving next cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_ack_reg  <= 2'b00;
      r_ce_reg   <= 1'b0;
      r_addr_reg <= '0;
      owner_reg  <= '0;
    end else begin
      r_ack_reg <= r_grant;
      r_ce_reg  <= |r_grant;
      if (r_grant[CLI_B])      r_addr_reg <= i_b_r_addr;
      else if (r_grant[CLI_A]) r_addr_reg <= i_a_r_addr;
      owner_reg <= '{valid: r_ce_reg, cli: r_ack_reg[CLI_B]};
    end
  end

  assign o_a_w_ack          = w_ack_reg[CLI_A];
  assign o_b_w_ack          = w_ack_reg[CLI_B];
  assign o_a_r_ack          = r_ack_reg[CLI_A];
  assign o_b_r_ack          = r_ack_reg[CLI_B];
  assign o_slave_w_ram_ce   = w_ce_reg;
  assign o_slave_w_ram_addr = w_addr_reg;
  assign o_slave_w_ram_din  = w_din_reg;
  assign o_slave_r_ram_ce   = r_ce_reg;
  assign o_slave_r_ram_addr = r_addr_reg;
  assign o_a_r_valid        = owner_reg.valid && (owner_reg.cli == CLI_A);
  assign o_b_r_valid        = owner_reg.valid && (owner_reg.cli == CLI_B);
  // BRAM output register is forwarded directly; zero when nothing is in flight.
  assign o_r_data           = owner_reg.valid ? i_slave_r_ram_dout : '0;

endmodule

// File: tb/tb_slave_ram_arbiter.sv
// Bench for slave_ram_arbiter: a round-robin instance backed by a BRAM model,
// plus a fixed-priority instance on the same stimulus for grant ordering.
module tb_slave_ram_arbiter;
  import slave_ram_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_w_req, b_w_req, a_r_req, b_r_req;
  logic [7:0]  a_w_addr, b_w_addr, a_r_addr, b_r_addr;
  logic [31:0] a_w_data, b_w_data;

  logic        a_w_ack, b_w_ack, a_r_ack, b_r_ack, a_r_valid, b_r_valid;
  logic [31:0] r_data, w_din, ram_dout;
  logic [7:0]  w_addr, r_addr;
  logic        w_ce, r_ce;

  logic        f_a_w_ack, f_b_w_ack, f_a_r_ack, f_b_r_ack, f_a_r_valid, f_b_r_valid;
  logic [31:0] f_r_data, f_w_din;
  logic [7:0]  f_w_addr, f_r_addr;
  logic        f_w_ce, f_r_ce;

  logic [31:0] ram_mem [256];
  logic [31:0] exp_mem [256];

  typedef struct {
    logic        cli;
    logic [31:0] data;
  } sb_entry_t;
  sb_entry_t sb_q[$];
  sb_entry_t sb_e;

  int n_cmp = 0;
  int n_err = 0;

  logic [87:0] all_out, fix_out;
  logic [1:0]  exp_g;

  assign all_out = {a_w_ack, b_w_ack, a_r_ack, b_r_ack, a_r_valid, b_r_valid,
                    r_data, w_addr, w_ce, w_din, r_addr, r_ce};
  assign fix_out = {f_a_w_ack, f_b_w_ack, f_a_r_ack, f_b_r_ack, f_a_r_valid, f_b_r_valid,
                    f_r_data, f_w_addr, f_w_ce, f_w_din, f_r_addr, f_r_ce};

  always #5 clk = ~clk;

  slave_ram_arbiter #(.ARB_MODE(ARB_RR)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_w_req(a_w_req), .i_a_w_addr(a_w_addr), .i_a_w_data(a_w_data), .o_a_w_ack(a_w_ack),
    .i_b_w_req(b_w_req), .i_b_w_addr(b_w_addr), .i_b_w_data(b_w_data), .o_b_w_ack(b_w_ack),
    .i_a_r_req(a_r_req), .i_a_r_addr(a_r_addr), .o_a_r_ack(a_r_ack), .o_a_r_valid(a_r_valid),
    .i_b_r_req(b_r_req), .i_b_r_addr(b_r_addr), .o_b_r_ack(b_r_ack), .o_b_r_valid(b_r_valid),
    .o_r_data(r_data),
    .o_slave_w_ram_addr(w_addr), .o_slave_w_ram_ce(w_ce), .o_slave_w_ram_din(w_din),
    .o_slave_r_ram_addr(r_addr), .o_slave_r_ram_ce(r_ce), .i_slave_r_ram_dout(ram_dout)
  );

  slave_ram_arbiter #(.ARB_MODE(ARB_FIXED)) u_fix (
    .i_clk(clk), .i_rst(rst),
    .i_a_w_req(a_w_req), .i_a_w_addr(a_w_addr), .i_a_w_data(a_w_data), .o_a_w_ack(f_a_w_ack),
    .i_b_w_req(b_w_req), .i_b_w_addr(b_w_addr), .i_b_w_data(b_w_data), .o_b_w_ack(f_b_w_ack),
    .i_a_r_req(a_r_req), .i_a_r_addr(a_r_addr), .o_a_r_ack(f_a_r_ack), .o_a_r_valid(f_a_r_valid),
    .i_b_r_req(b_r_req), .i_b_r_addr(b_r_addr), .o_b_r_ack(f_b_r_ack), .o_b_r_valid(f_b_r_valid),
    .o_r_data(f_r_data),
    .o_slave_w_ram_addr(f_w_addr), .o_slave_w_ram_ce(f_w_ce), .o_slave_w_ram_din(f_w_din),
    .o_slave_r_ram_addr(f_r_addr), .o_slave_r_ram_ce(f_r_ce), .i_slave_r_ram_dout(32'h0)
  );

  // Read-first BRAM with registered output.
  always @(posedge clk) begin
    if (r_ce) ram_dout <= ram_mem[r_addr];
    if (w_ce) ram_mem[w_addr] <= w_din;
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic cli, input logic [31:0] data);
    sb_entry_t e;
    e.cli  = cli;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Scoreboard: every read-valid pulse must match the oldest expected read.
  always @(negedge clk) begin
    if (a_r_valid || b_r_valid) begin
      if (sb_q.size() == 0) begin
        chk("spurious_valid", {94'd0, a_r_valid, b_r_valid}, 96'd0);
      end else begin
        sb_e = sb_q.pop_front();
        chk("rd_owner", {94'd0, a_r_valid, b_r_valid},
            (sb_e.cli == CLI_A) ? 96'd2 : 96'd1);
        chk("rd_data", {64'd0, r_data}, {64'd0, sb_e.data});
        $display("read  cli=%0d data=%h exp=%h", a_r_valid ? 0 : 1, r_data, sb_e.data);
      end
    end
  end

  initial begin
    rst = 1'b0;
    a_w_req = 0; b_w_req = 0; a_r_req = 0; b_r_req = 0;
    a_w_addr = 0; b_w_addr = 0; a_r_addr = 0; b_r_addr = 0;
    a_w_data = 0; b_w_data = 0;
    repeat (3) tick();
    chk("reset_outputs", {8'd0, all_out}, 96'd0);
    chk("reset_fix_outputs", {8'd0, fix_out}, 96'd0);
    rst = 1'b1;
    tick();

    // Single write from A.
    a_w_req = 1; a_w_addr = 8'h10; a_w_data = 32'hDEADBEEF;
    exp_mem[8'h10] = 32'hDEADBEEF;
    tick();
    $display("write cli=0 addr=10 data=deadbeef");
    chk("w1_port", {55'd0, w_ce, w_addr, w_din}, {55'd0, 1'b1, 8'h10, 32'hDEADBEEF});
    chk("w1_acks", {91'd0, a_w_ack, b_w_ack, a_r_ack, b_r_ack, r_ce}, {91'd0, 5'b10000});
    a_w_req = 0;
    tick();
    chk("w1_idle_hold", {55'd0, w_ce, a_w_ack, w_addr, w_din}, {55'd0, 2'b00, 8'h10, 32'hDEADBEEF});

    // B reads it back: ack at N+1, valid at N+2.
    sb_push(CLI_B, exp_mem[8'h10]);
    b_r_req = 1; b_r_addr = 8'h10;
    tick();
    chk("r1_ack", {85'd0, a_r_ack, b_r_ack, r_ce, r_addr}, {85'd0, 3'b011, 8'h10});
    chk("r1_no_early_valid", {94'd0, a_r_valid, b_r_valid}, 96'd0);
    b_r_req = 0;
    tick();
    chk("r1_valid", {94'd0, a_r_valid, b_r_valid}, 96'd1);
    tick();
    chk("r1_valid_pulse", {94'd0, a_r_valid, b_r_valid}, 96'd0);

    // Re-center pointers, then write contention from both clients.
    rst = 0; tick(); rst = 1; tick();
    a_w_req = 1; a_w_addr = 8'h01; a_w_data = 32'h11;
    b_w_req = 1; b_w_addr = 8'h02; b_w_data = 32'h22;
    exp_mem[8'h01] = 32'h11; exp_mem[8'h02] = 32'h22;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      $display("write contention cycle %0d grant a=%0d b=%0d", i, a_w_ack, b_w_ack);
      chk("rr_w_grant", {94'd0, a_w_ack, b_w_ack}, {94'd0, exp_g});
      chk("rr_w_addr", {88'd0, w_addr}, (i % 2 == 0) ? 96'h01 : 96'h02);
      chk("fx_w_grant", {94'd0, f_a_w_ack, f_b_w_ack}, {94'd0, exp_g});
    end
    a_w_req = 0; b_w_req = 0;
    tick();

    // A alone moves the RR pointer to B; fixed still prefers A.
    a_w_req = 1; a_w_addr = 8'h03; a_w_data = 32'h33; exp_mem[8'h03] = 32'h33;
    tick();
    chk("solo_a_grant", {92'd0, a_w_ack, b_w_ack, f_a_w_ack, f_b_w_ack}, {92'd0, 4'b1010});
    a_w_req = 0;
    tick();
    a_w_req = 1; a_w_addr = 8'h04; a_w_data = 32'h44; exp_mem[8'h04] = 32'h44;
    b_w_req = 1; b_w_addr = 8'h05; b_w_data = 32'h55; exp_mem[8'h05] = 32'h55;
    tick();
    chk("ptr_rr_first_b", {94'd0, a_w_ack, b_w_ack}, 96'd1);
    chk("ptr_fx_first_a", {94'd0, f_a_w_ack, f_b_w_ack}, 96'd2);
    tick();
    chk("ptr_rr_then_a", {94'd0, a_w_ack, b_w_ack}, 96'd2);
    chk("ptr_fx_then_b", {94'd0, f_a_w_ack, f_b_w_ack}, 96'd1);
    a_w_req = 0; b_w_req = 0;
    tick();

    // Read contention on both instances.
    for (int i = 0; i < 2; i++) begin
      sb_push(CLI_A, exp_mem[8'h01]);
      sb_push(CLI_B, exp_mem[8'h02]);
    end
    a_r_req = 1; a_r_addr = 8'h01; b_r_req = 1; b_r_addr = 8'h02;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      chk("rr_r_grant", {94'd0, a_r_ack, b_r_ack}, {94'd0, exp_g});
      chk("fx_r_grant", {94'd0, f_a_r_ack, f_b_r_ack}, {94'd0, exp_g});
    end
    a_r_req = 0; b_r_req = 0;
    repeat (3) tick();

    // Same-cycle write and read of one address returns the old word.
    a_w_req = 1; a_w_addr = 8'h20; a_w_data = 32'd5; exp_mem[8'h20] = 32'd5;
    tick(); a_w_req = 0; tick();
    sb_push(CLI_B, exp_mem[8'h20]);
    exp_mem[8'h20] = 32'd9;
    a_w_req = 1; a_w_data = 32'd9; b_r_req = 1; b_r_addr = 8'h20;
    tick();
    chk("hz_same_cycle", {92'd0, a_w_ack, b_r_ack, w_ce, r_ce}, {92'd0, 4'b1111});
    a_w_req = 0; b_r_req = 0;
    tick();
    chk("hz_old_valid", {94'd0, a_r_valid, b_r_valid}, 96'd1);
    sb_push(CLI_A, exp_mem[8'h20]);
    a_r_req = 1; a_r_addr = 8'h20;
    tick(); a_r_req = 0; tick();
    chk("hz_new_valid", {94'd0, a_r_valid, b_r_valid}, 96'd2);

    // Reset in the cycle a read ack is visible cancels its valid.
    tick();
    a_r_req = 1; a_r_addr = 8'h10;
    tick();
    chk("mid_rst_ack", {95'd0, a_r_ack}, 96'd1);
    rst = 0; a_r_req = 0;
    tick();
    chk("mid_rst_outputs", {8'd0, all_out}, 96'd0);
    chk("mid_rst_fix_outputs", {8'd0, fix_out}, 96'd0);
    tick();
    chk("mid_rst_still_zero", {8'd0, all_out}, 96'd0);
    rst = 1;
    tick();

    // Pointers back at A on both ports after reset.
    a_w_req = 1; a_w_addr = 8'h30; a_w_data = 32'h300; exp_mem[8'h30] = 32'h300;
    b_w_req = 1; b_w_addr = 8'h40; b_w_data = 32'h400; exp_mem[8'h40] = 32'h400;
    tick();
    chk("post_rst_w_ptr", {94'd0, a_w_ack, b_w_ack}, 96'd2);
    tick();
    chk("post_rst_w_next", {94'd0, a_w_ack, b_w_ack}, 96'd1);
    a_w_req = 0; b_w_req = 0;
    tick();
    sb_push(CLI_A, exp_mem[8'h30]);
    sb_push(CLI_B, exp_mem[8'h40]);
    a_r_req = 1; a_r_addr = 8'h30; b_r_req = 1; b_r_addr = 8'h40;
    tick();
    chk("post_rst_r_ptr", {94'd0, a_r_ack, b_r_ack}, 96'd2);
    tick();
    chk("post_rst_r_next", {94'd0, a_r_ack, b_r_ack}, 96'd1);
    a_r_req = 0; b_r_req = 0;

    // Drain outstanding reads within a bounded window.
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    chk("sb_drain", sb_q.size(), 96'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
